// File: rtl/mem_copy_engine_if.sv
// Memory-side bus between the copy engine (master) and the 16-word data memory (slave).
// The read/write strobes are active-low. Read data is registered by the memory.
interface mem_copy_engine_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd_n;
    logic              mem_wr_n;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_rd_n,
        output mem_wr_n,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_rd_n,
        input  mem_wr_n,
        output mem_rdata
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / block fill initiator for the 16-word data memory.
// One start pulse runs a whole transfer; bus outputs are decoded from registered state only.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// RD    | read strobe low at src+i
// LAT   | strobes high; registered read data captured into data_q
// WR    | write strobe low at dst+i, then i advances
// DONE  | one-cycle completion pulse
module mem_copy_engine #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [4:0]        len,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    mem_copy_engine_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_LAT  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [4:0] LEN_MAX = 5'd16;

    logic [2:0]        state_q, state_d;
    logic [4:0]        i_q, i_d;
    logic [4:0]        len_q, len_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [4:0] len_clamped;
    logic [4:0] i_inc;

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
    assign i_inc       = i_q + 5'd1;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        len_d   = len_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        pat_d   = pat_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    src_d = src;
                    dst_d = dst;
                    len_d = len_clamped;
                    pat_d = pattern;
                    i_d   = 5'd0;
                    if (len_clamped == 5'd0) state_d = S_DONE;
                    else if (op)             state_d = S_WR;
                    else                     state_d = S_RD;
                end
            end
            S_RD:  state_d = S_LAT;
            S_LAT: begin
                data_d  = bus.mem_rdata;
                state_d = S_WR;
            end
            S_WR: begin
                i_d = i_inc;
                if (i_inc == len_q) state_d = S_DONE;
                else if (op_q)      state_d = S_WR;
                else                state_d = S_RD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            len_q   <= '0;
            op_q    <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            pat_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            len_q   <= len_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            pat_q   <= pat_d;
            data_q  <= data_d;
        end
    end

    // Addresses wrap modulo the memory size through the ADDR_W-bit adders.
    always_comb begin
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_rd_n  = 1'b1;
        bus.mem_wr_n  = 1'b1;
        case (state_q)
            S_RD: begin
                bus.mem_addr = src_q + i_q[ADDR_W-1:0];
                bus.mem_rd_n = 1'b0;
            end
            S_WR: begin
                bus.mem_addr  = dst_q + i_q[ADDR_W-1:0];
                bus.mem_wdata = op_q ? pat_q : data_q;
                bus.mem_wr_n  = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural 16x4 memory on the bus.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_mem_copy_engine;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [3:0] src = '0;
    logic [3:0] dst = '0;
    logic [4:0] len = '0;
    logic [3:0] pattern = '0;
    logic       busy, done;

    mem_copy_engine_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    mem_copy_engine #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .op      (op),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .pattern (pattern),
        .busy    (busy),
        .done    (done),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // mem_mode: 0 normal, 1 load mem[k]=k, 2 load all zero
    logic [3:0] mem [16];
    int         mem_mode = 0;

    always @(posedge clk) begin
        if (mem_mode == 1) begin
            for (int k = 0; k < 16; k++) mem[k] <= 4'(k);
        end else if (mem_mode == 2) begin
            for (int k = 0; k < 16; k++) mem[k] <= 4'd0;
        end else begin
            if (!bus.mem_wr_n) mem[bus.mem_addr] <= bus.mem_wdata;
            if (!bus.mem_rd_n) bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int         rd_cnt = 0;
    int         wr_cnt = 0;
    int         both_low = 0;
    logic [3:0] wr_addr_log [512];
    logic [3:0] wr_data_log [512];

    always @(negedge clk) begin
        if (!bus.mem_rd_n) rd_cnt++;
        if (!bus.mem_wr_n) begin
            wr_addr_log[wr_cnt] = bus.mem_addr;
            wr_data_log[wr_cnt] = bus.mem_wdata;
            wr_cnt++;
        end
        if (!bus.mem_rd_n && !bus.mem_wr_n) both_low++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input int mode);
        @(negedge clk);
        mem_mode = mode;
        @(negedge clk);
        mem_mode = 0;
    endtask

    // Issues one command and follows it until busy drops; glitch re-pulses start mid-run.
    task automatic run_cmd(input logic o, input logic [3:0] s, input logic [3:0] d,
                           input logic [4:0] l, input logic [3:0] p, input bit glitch,
                           output int bcyc, output int done_at, output int dones);
        bit finished;
        bcyc = 0; done_at = 0; dones = 0; finished = 0;
        @(negedge clk);
        start = 1'b1; op = o; src = s; dst = d; len = l; pattern = p;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) begin
                finished = 1;
                break;
            end
            bcyc++;
            if (done) begin
                dones++;
                done_at = bcyc;
            end
            if (glitch && c == 1) begin
                start = 1'b1; op = 1'b1; src = 4'd0; dst = 4'd0; len = 5'd5; pattern = 4'd15;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!finished) chk("cmd_timeout", 32'd1, 32'd0);
    endtask

    int bc, da, dn, w0, r0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_rd_n",  bus.mem_rd_n, 1);
        chk("rst_wr_n",  bus.mem_wr_n, 1);
        chk("rst_addr",  bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        clr = 1'b1;

        // copy 2 -> 10, three words
        load_mem(1);
        run_cmd(1'b0, 4'd2, 4'd10, 5'd3, 4'd0, 0, bc, da, dn);
        chk("cp_m10", mem[10], 2);
        chk("cp_m11", mem[11], 3);
        chk("cp_m12", mem[12], 4);
        chk("cp_m13", mem[13], 13);
        chk("cp_busy", bc, 10);
        chk("cp_done_n", dn, 1);
        chk("cp_done_at", da, 10);

        // fill wrapping 14,15,0,1
        w0 = wr_cnt; r0 = rd_cnt;
        run_cmd(1'b1, 4'd0, 4'd14, 5'd4, 4'd9, 0, bc, da, dn);
        chk("fl_writes", wr_cnt - w0, 4);
        chk("fl_reads", rd_cnt - r0, 0);
        chk("fl_busy", bc, 5);
        chk("fl_a0", wr_addr_log[w0],     14);
        chk("fl_a1", wr_addr_log[w0 + 1], 15);
        chk("fl_a2", wr_addr_log[w0 + 2], 0);
        chk("fl_a3", wr_addr_log[w0 + 3], 1);
        for (int k = 0; k < 4; k++) chk("fl_data", wr_data_log[w0 + k], 9);
        chk("fl_m15", mem[15], 9);
        chk("fl_m2", mem[2], 2);

        // zero length copy
        w0 = wr_cnt; r0 = rd_cnt;
        run_cmd(1'b0, 4'd3, 4'd7, 5'd0, 4'd0, 0, bc, da, dn);
        chk("l0_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        chk("l0_busy", bc, 1);
        chk("l0_done_at", da, 1);

        // over-length fill clamps to 16
        w0 = wr_cnt;
        run_cmd(1'b1, 4'd0, 4'd0, 5'd20, 4'd5, 0, bc, da, dn);
        chk("l20_writes", wr_cnt - w0, 16);
        chk("l20_busy", bc, 17);
        chk("l20_last_addr", wr_addr_log[w0 + 15], 15);

        // overlapping copy propagates mem[0] forward (1,2,3 would appear without propagation)
        load_mem(1);
        run_cmd(1'b0, 4'd0, 4'd1, 5'd4, 4'd0, 0, bc, da, dn);
        chk("ov_m1", mem[1], 0);
        chk("ov_m2", mem[2], 0);
        chk("ov_m3", mem[3], 0);
        chk("ov_m4", mem[4], 0);
        chk("ov_m5", mem[5], 5);

        // start pulse during a copy is ignored
        load_mem(1);
        w0 = wr_cnt;
        run_cmd(1'b0, 4'd4, 4'd8, 5'd2, 4'd0, 1, bc, da, dn);
        chk("gl_m8", mem[8], 4);
        chk("gl_m9", mem[9], 5);
        chk("gl_m0", mem[0], 0);
        chk("gl_writes", wr_cnt - w0, 2);
        chk("gl_busy", bc, 7);
        repeat (3) @(negedge clk);
        chk("gl_idle", busy, 0);

        // clear during the second write of a three word copy
        load_mem(1);
        @(negedge clk);
        start = 1'b1; op = 1'b0; src = 4'd3; dst = 4'd12; len = 5'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("cl_in_wr", bus.mem_wr_n, 0);
        clr = 1'b0;
        #1;
        chk("cl_busy",  busy, 0);
        chk("cl_done",  done, 0);
        chk("cl_rd_n",  bus.mem_rd_n, 1);
        chk("cl_wr_n",  bus.mem_wr_n, 1);
        chk("cl_addr",  bus.mem_addr, 0);
        chk("cl_wdata", bus.mem_wdata, 0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("cl_m12", mem[12], 3);
        chk("cl_m13", mem[13], 13);
        chk("cl_m14", mem[14], 14);
        run_cmd(1'b1, 4'd0, 4'd13, 5'd1, 4'd7, 0, bc, da, dn);
        chk("cl_after_m13", mem[13], 7);
        chk("cl_after_busy", bc, 2);

        chk("never_both_low", both_low, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
